gerenciador_necessidades: RTL and testbench

- Needs scheduler for the pet. It sits beside controlador_estados and is driven by the same 100 Hz clk.
- Once per second it updates three need levels (saciedade, energia, dinheiro) according to the current estado.
- It generates the morreu input of controlador_estados and signals when an activity has finished.
- It is the block that sequences the life-cycle timing of the state controller.

---
 rtl/gerenciador_necessidades.sv | 122 ++++++++++++
 tb/tb_gerenciador_necessidades.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_necessidades.sv
// Needs scheduler for the pet: once per second it updates saciedade/energia/dinheiro from estado,
// raises the sticky morreu flag and pulses fim_atividade. Define TICK_RAPIDO_EN to tick every clk.
module gerenciador_necessidades #(
  parameter int CLK_HZ    = 100,
  parameter int W         = 4,
  parameter int NIVEL_MAX = 15,
  parameter int SAC_INI   = 10,
  parameter int ENE_INI   = 10,
  parameter int DIN_INI   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   estado,
  output logic [W-1:0] saciedade,
  output logic [W-1:0] energia,
  output logic [W-1:0] dinheiro,
  output logic         morreu,
  output logic         tick_1s,
  output logic         fim_atividade
);

  localparam logic [3:0] ST_IDLE       = 4'b0001;
  localparam logic [3:0] ST_COMENDO    = 4'b0010;
  localparam logic [3:0] ST_DORMINDO   = 4'b0100;
  localparam logic [3:0] ST_DANDO_AULA = 4'b1000;

  localparam logic [W-1:0] MAXV = W'(NIVEL_MAX);

`ifdef TICK_RAPIDO_EN
  // Fast-simulation mode: every cycle out of reset is a tick.
  assign tick_1s = rst_n;
`else
  localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_HZ - 1);

  logic [DW-1:0] divider;
  logic [DW-1:0] div_next;

  assign div_next = (divider == LAST) ? '0 : divider + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divider <= '0;
      tick_1s <= 1'b0;
    end else begin
      divider <= div_next;
      tick_1s <= (div_next == LAST);
    end
  end
`endif

  function automatic logic [W-1:0] sat(input int v);
    if (v < 0)              return '0;
    else if (v > NIVEL_MAX) return MAXV;
    else                    return W'(v);
  endfunction

  int          d_sac, d_ene, d_din;
  logic        sem_dinheiro;
  logic [W-1:0] sac_new, ene_new, din_new;
  logic        dead, fim_req;

  // NOTE: every signal gets a default before the case so no latch is inferred for unlisted states.
  always_comb begin
    d_sac        = -1;
    d_ene        = -1;
    d_din        = 0;
    sem_dinheiro = 1'b0;
    case (estado)
      ST_COMENDO: begin
        if (dinheiro != '0) begin
          d_sac = 3;
          d_ene = 0;
          d_din = -1;
        end else begin
          sem_dinheiro = 1'b1;
        end
      end
      ST_DORMINDO:   d_ene = 2;
      ST_DANDO_AULA: begin
        d_ene = -2;
        d_din = 1;
      end
      default: ;
    endcase

    sac_new = sat(int'(saciedade) + d_sac);
    ene_new = sat(int'(energia) + d_ene);
    din_new = sat(int'(dinheiro) + d_din);
    dead    = (sac_new == '0) || (ene_new == '0);

    fim_req = sem_dinheiro
           || ((estado == ST_COMENDO) && (dinheiro != '0) && (sac_new == MAXV))
           || ((estado == ST_DORMINDO) && (ene_new == MAXV))
           || ((estado == ST_DANDO_AULA) && (ene_new <= W'(2)));
  end

  // Death wins over fim_atividade, and once dead the levels freeze until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saciedade     <= W'(SAC_INI);
      energia       <= W'(ENE_INI);
      dinheiro      <= W'(DIN_INI);
      morreu        <= 1'b0;
      fim_atividade <= 1'b0;
    end else begin
      fim_atividade <= 1'b0;
      if (tick_1s && !morreu) begin
        saciedade     <= sac_new;
        energia       <= ene_new;
        dinheiro      <= din_new;
        morreu        <= dead;
        fim_atividade <= fim_req && !dead;
      end
    end
  end

  logic unused_idle;
  assign unused_idle = (ST_IDLE == 4'b0001);

endmodule

// File: tb/tb_gerenciador_necessidades.sv
// Self-checking bench for gerenciador_necessidades (default build, 1 s divider) against a
// per-second arithmetic model of the pet's needs.
module tb_gerenciador_necessidades;

  localparam int CLK_HZ = 100;
  localparam int NMAX   = 15;

  localparam logic [3:0] E_MORTO = 4'b0000;
  localparam logic [3:0] E_IDLE  = 4'b0001;
  localparam logic [3:0] E_COME  = 4'b0010;
  localparam logic [3:0] E_DORME = 4'b0100;
  localparam logic [3:0] E_AULA  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] estado;
  logic [3:0] saciedade, energia, dinheiro;
  logic       morreu, tick_1s, fim_atividade;

  int n_cmp = 0;
  int n_bad = 0;

  int m_sac, m_ene, m_din;
  bit m_morreu, m_fim;

  gerenciador_necessidades #(
    .CLK_HZ(CLK_HZ), .W(4), .NIVEL_MAX(NMAX), .SAC_INI(10), .ENE_INI(10), .DIN_INI(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado),
    .saciedade(saciedade), .energia(energia), .dinheiro(dinheiro),
    .morreu(morreu), .tick_1s(tick_1s), .fim_atividade(fim_atividade)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > NMAX) ? NMAX : v);
  endfunction

  task automatic model_reset();
    m_sac = 10; m_ene = 10; m_din = 5; m_morreu = 0; m_fim = 0;
  endtask

  // One second of the pet's life, straight from the rules table.
  task automatic model_step(input logic [3:0] e);
    int s, en, d;
    bit want_fim;
    m_fim = 0;
    if (m_morreu) return;
    s = m_sac - 1; en = m_ene - 1; d = m_din; want_fim = 0;
    if (e == E_COME) begin
      if (m_din > 0) begin
        s = m_sac + 3; en = m_ene; d = m_din - 1;
        want_fim = (clamp(s) == NMAX);
      end else begin
        want_fim = 1;
      end
    end else if (e == E_DORME) begin
      en = m_ene + 2;
      want_fim = (clamp(en) == NMAX);
    end else if (e == E_AULA) begin
      en = m_ene - 2; d = m_din + 1;
      want_fim = (clamp(en) <= 2);
    end
    m_sac = clamp(s); m_ene = clamp(en); m_din = clamp(d);
    if (m_sac == 0 || m_ene == 0) m_morreu = 1;
    else m_fim = want_fim;
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (saciedade !== 4'd10 || energia !== 4'd10 || dinheiro !== 4'd5 ||
        morreu !== 1'b0 || tick_1s !== 1'b0 || fim_atividade !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got sac=%0d ene=%0d din=%0d morreu=%b tick=%b fim=%b want 10/10/5/0/0/0",
               tag, saciedade, energia, dinheiro, morreu, tick_1s, fim_atividade);
    end
  endtask

  // Assert reset between edges, check the asynchronous effect, release on a falling edge.
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    @(posedge clk);
    #1 check_reset_vals({tag, "_held"});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the next tick (expected CLK_HZ-1 falling edges away), applies estado e for that
  // tick and compares the following cycle against the model.
  task automatic do_second(input logic [3:0] e, input bit scramble);
    int  n;
    bit  got;
    n = 0; got = 0;
    while (!got && n < 2 * CLK_HZ) begin
      @(negedge clk);
      n++;
      if (tick_1s === 1'b1) got = 1;
      else begin
        n_cmp++;
        if (fim_atividade !== 1'b0) begin
          n_bad++;
          $display("FAIL fim_between_ticks: got %b want 0 (cycle %0d)", fim_atividade, n);
        end
        if (scramble) estado = 4'($urandom_range(0, 15));
      end
    end
    n_cmp++;
    if (!got || n != CLK_HZ - 1) begin
      n_bad++;
      $display("FAIL tick_gap: got %0d cycles (seen=%0d) want %0d", n, got, CLK_HZ - 1);
      return;
    end
    estado = e;
    model_step(e);
    @(negedge clk);
    n_cmp++;
    if (saciedade !== 4'(m_sac) || energia !== 4'(m_ene) || dinheiro !== 4'(m_din)) begin
      n_bad++;
      $display("FAIL levels(estado=%b): got %0d/%0d/%0d want %0d/%0d/%0d",
               e, saciedade, energia, dinheiro, m_sac, m_ene, m_din);
    end
    n_cmp++;
    if (morreu !== m_morreu || fim_atividade !== m_fim) begin
      n_bad++;
      $display("FAIL flags(estado=%b): got morreu=%b fim=%b want morreu=%b fim=%b",
               e, morreu, fim_atividade, m_morreu, m_fim);
    end
    n_cmp++;
    if (tick_1s !== 1'b0) begin
      n_bad++;
      $display("FAIL tick_width: got %b want 0 after the tick cycle", tick_1s);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    estado = E_IDLE;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset_initial");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    repeat (3) do_second(E_IDLE, 0);
    n_cmp++;
    if (saciedade !== 4'd7 || energia !== 4'd7 || dinheiro !== 4'd5 || morreu !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_3s: got %0d/%0d/%0d morreu=%b want 7/7/5 morreu=0",
               saciedade, energia, dinheiro, morreu);
    end
  endtask

  task automatic test_comendo();
    repeat (3) do_second(E_COME, 1);
    n_cmp++;
    if (saciedade !== 4'd15 || energia !== 4'd7 || dinheiro !== 4'd2) begin
      n_bad++;
      $display("FAIL comendo_3s: got %0d/%0d/%0d want 15/7/2", saciedade, energia, dinheiro);
    end
  endtask

  task automatic test_sem_dinheiro();
    repeat (2) do_second(E_COME, 1);
    do_second(E_COME, 1);
    n_cmp++;
    if (dinheiro !== 4'd0 || saciedade !== 4'd14 || energia !== 4'd6) begin
      n_bad++;
      $display("FAIL sem_dinheiro: got %0d/%0d/%0d want 14/6/0", saciedade, energia, dinheiro);
    end
  endtask

  task automatic test_aula_morte();
    apply_reset("reset_before_aula");
    repeat (5) do_second(E_AULA, 1);
    n_cmp++;
    if (morreu !== 1'b1 || energia !== 4'd0) begin
      n_bad++;
      $display("FAIL aula_morte: got morreu=%b ene=%0d want morreu=1 ene=0", morreu, energia);
    end
    do_second(E_DORME, 1);
    do_second(E_COME, 1);
    do_second(E_MORTO, 1);
  endtask

  task automatic test_reset_mid();
    apply_reset("reset_before_dorme");
    do_second(E_DORME, 0);
    repeat (49) @(negedge clk);
    apply_reset("reset_mid_second");
    do_second(E_DORME, 1);
  endtask

  task automatic test_random();
    logic [3:0] pick [6] = '{E_IDLE, E_COME, E_DORME, E_AULA, E_MORTO, 4'b1011};
    for (int i = 0; i < 40; i++) begin
      if (m_morreu && $urandom_range(0, 3) == 0) apply_reset("reset_random");
      do_second(pick[$urandom_range(0, 5)], 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_comendo();
    test_sem_dinheiro();
    test_aula_morte();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
